// File: rtl/core_logic_gen.sv
// JTAG core-logic data register: Fibonacci / counter / Galois-LFSR generator with a capture/shift/update DR.
// Define CORE_LOGIC_OVF_EN to build the sticky overflow flag; otherwise CORE_LOGIC_OVF is tied low.
module core_logic_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             TCK,
  input  logic             rst,
  input  logic             TDI,
  input  logic             CAPTUREDR,
  input  logic             SHIFTDR,
  input  logic             UPDATEDR,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] CORE_LOGIC_BSR,
  output logic             CORE_LOGIC_TDO,
  output logic             CORE_LOGIC_OVF
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_FIB   = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] previous, current, shreg;
  logic [WIDTH-1:0] prev_nxt, cur_nxt, sh_nxt;
  logic [SUM_W-1:0] fib_sum;
  logic             ovf_set;

  assign mode    = mode_t'(MODE);
  assign fib_sum = SUM_W'({1'b0, current}) + SUM_W'({1'b0, previous});

  // One action per cycle: update > capture > shift > advance.
  always_comb begin
    prev_nxt = previous;
    cur_nxt  = current;
    sh_nxt   = shreg;
    ovf_set  = 1'b0;
    if (UPDATEDR) begin
      prev_nxt = '0;
      cur_nxt  = (mode == MODE_LFSR && shreg == '0) ? WIDTH'(1) : shreg;
    end else if (CAPTUREDR) begin
      sh_nxt = current;
    end else if (SHIFTDR) begin
      sh_nxt = {TDI, shreg[WIDTH-1:1]};
    end else begin
      unique case (mode)
        MODE_FIB: begin
          prev_nxt = current;
          cur_nxt  = fib_sum[WIDTH-1:0];
          ovf_set  = fib_sum[WIDTH];
        end
        MODE_COUNT: begin
          prev_nxt = current;
          cur_nxt  = current + WIDTH'(1);
          ovf_set  = &current;
        end
        MODE_LFSR: begin
          prev_nxt = current;
          // All-zero is the LFSR lock-up state; kick it back to 1.
          if (current == '0) cur_nxt = WIDTH'(1);
          else               cur_nxt = (current >> 1) ^ (current[0] ? LFSR_TAPS : '0);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge TCK) begin
    if (!rst) begin
      previous <= '0;
      current  <= SEED;
      shreg    <= '0;
    end else begin
      previous <= prev_nxt;
      current  <= cur_nxt;
      shreg    <= sh_nxt;
    end
  end

`ifdef CORE_LOGIC_OVF_EN
  logic ovf;

  always_ff @(posedge TCK) begin
    if (!rst) ovf <= 1'b0;
    else      ovf <= ovf | ovf_set;
  end

  assign CORE_LOGIC_OVF = ovf;
`else
  logic unused_ovf_set;
  assign unused_ovf_set = ovf_set;
  assign CORE_LOGIC_OVF = 1'b0;
`endif

  assign CORE_LOGIC_BSR = current;
  assign CORE_LOGIC_TDO = shreg[0];

endmodule
